// File: rtl/vga_plot_arbiter_pkg.sv
// rtl/vga_plot_arbiter_pkg.sv - shared widths, state codes and pixel type for the plot arbiter
package vga_plot_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// rtl/vga_plot_arbiter_if.sv - requester bundle and adapter-side pixel port of the plot arbiter
interface vga_plot_arbiter_if #(
    parameter int N_REQ = 3
) ();

    logic [N_REQ-1:0]                        req;
    logic [N_REQ-1:0]                        valid;
    logic [N_REQ-1:0]                        last;
    logic [vga_plot_pkg::X_W*N_REQ-1:0]      px_x;
    logic [vga_plot_pkg::Y_W*N_REQ-1:0]      px_y;
    logic [vga_plot_pkg::COLOUR_W*N_REQ-1:0] px_colour;
    logic                                    freeze;

    logic [N_REQ-1:0]                        gnt;
    logic [vga_plot_pkg::X_W-1:0]            x;
    logic [vga_plot_pkg::Y_W-1:0]            y;
    logic [vga_plot_pkg::COLOUR_W-1:0]       colour;
    logic                                    plot;
    logic                                    busy;
    logic                                    timeout;

    modport master (
        output req, valid, last, px_x, px_y, px_colour, freeze,
        input  gnt, x, y, colour, plot, busy, timeout
    );

    modport slave (
        input  req, valid, last, px_x, px_y, px_colour, freeze,
        output gnt, x, y, colour, plot, busy, timeout
    );

endinterface

// File: rtl/vga_plot_arbiter_rr_picker.sv
// rtl/vga_plot_arbiter_rr_picker.sv - combinational round-robin winner search starting after the pointer
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    int   cand;
    logic found;

    // Walk ptr+1, ptr+2, ... wrapping at N_REQ; the first set request wins.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_idx          = IDX_W'(cand);
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin owner of the VGA adapter pixel-write port
module vga_plot_arbiter
    import vga_plot_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int IDLE_LIMIT = 255
) (
    input logic               clk,
    input logic               resetn,
    vga_plot_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);

    logic [1:0]       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic             timeout_q;
    logic             plot_q;
    pixel_t           pix_q;

    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             own_valid;
    logic             own_last;
    pixel_t           own_pix;
    logic             arb_go;
    logic             idle_hit;
    logic [CNT_W-1:0] idle_inc;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (bus.req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // The pointer doubles as the owner index while in GRANT; select the owner's lane.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_pix   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ptr_q == IDX_W'(i)) begin
                own_valid      = bus.valid[i];
                own_last       = bus.last[i];
                own_pix.x      = bus.px_x[i*X_W +: X_W];
                own_pix.y      = bus.px_y[i*Y_W +: Y_W];
                own_pix.colour = bus.px_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign arb_go   = (state_q != ST_GRANT) && !bus.freeze && (|bus.req);
    assign idle_hit = (idle_cnt_q >= CNT_W'(IDLE_LIMIT - 1));
    assign idle_inc = (idle_cnt_q == {CNT_W{1'b1}}) ? idle_cnt_q : idle_cnt_q + 1'b1;

    // Burst FSM: arbitrate from IDLE/GAP, hold the owner until last pixel or stall timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_GRANT: begin
                    if (own_valid) begin
                        idle_cnt_q <= '0;
                        if (own_last) begin
                            state_q <= ST_GAP;
                            gnt_q   <= '0;
                        end
                    end else if (idle_hit) begin
                        idle_cnt_q <= idle_inc;
                        state_q    <= ST_GAP;
                        gnt_q      <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_inc;
                    end
                end
                default: begin
                    if (arb_go) begin
                        state_q    <= ST_GRANT;
                        gnt_q      <= win_onehot;
                        ptr_q      <= win_idx;
                        idle_cnt_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Registered pixel port: only the owner's valid pixels reach the adapter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            plot_q <= (state_q == ST_GRANT) && own_valid;
            if ((state_q == ST_GRANT) && own_valid) begin
                pix_q <= own_pix;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.x       = pix_q.x;
    assign bus.y       = pix_q.y;
    assign bus.colour  = pix_q.colour;
    assign bus.plot    = plot_q;
    assign bus.busy    = (state_q == ST_GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    localparam int N_REQ      = 3;
    localparam int IDLE_LIMIT = 8;

    logic clk = 1'b0;
    logic resetn;
    logic cmp_en = 1'b0;

    vga_plot_arbiter_if #(.N_REQ(N_REQ)) bus ();

    vga_plot_arbiter #(
        .N_REQ      (N_REQ),
        .IDLE_LIMIT (IDLE_LIMIT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, what the adapter last received.
    int          m_owner;
    int          m_last_win;
    int          m_idle;
    int          mc;
    logic        m_found;
    logic        m_plot;
    logic        m_timeout;
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic [23:0] m_c;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_owner    = -1;
            m_last_win = N_REQ - 1;
            m_idle     = 0;
            m_plot     = 1'b0;
            m_timeout  = 1'b0;
            m_x        = '0;
            m_y        = '0;
            m_c        = '0;
        end else begin
            m_timeout = 1'b0;
            if (m_owner < 0) begin
                m_plot = 1'b0;
                if (!bus.freeze && bus.req != 0) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= N_REQ; k++) begin
                        mc = (m_last_win + k) % N_REQ;
                        if (!m_found && bus.req[mc]) begin
                            m_found = 1'b1;
                            m_owner = mc;
                        end
                    end
                    m_last_win = m_owner;
                    m_idle     = 0;
                end
            end else if (bus.valid[m_owner]) begin
                m_plot = 1'b1;
                m_x    = bus.px_x[m_owner*8 +: 8];
                m_y    = bus.px_y[m_owner*7 +: 7];
                m_c    = bus.px_colour[m_owner*24 +: 24];
                m_idle = 0;
                if (bus.last[m_owner]) m_owner = -1;
            end else begin
                m_plot = 1'b0;
                m_idle = m_idle + 1;
                if (m_idle >= IDLE_LIMIT) begin
                    m_owner   = -1;
                    m_timeout = 1'b1;
                end
            end
        end
    end

    // Every cycle, away from the active edge, hold the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("cyc_busy", 32'(bus.busy), (m_owner < 0) ? 32'd0 : 32'd1);
            chk("cyc_plot", 32'(bus.plot), 32'(m_plot));
            chk("cyc_timeout", 32'(bus.timeout), 32'(m_timeout));
            chk("cyc_x", 32'(bus.x), 32'(m_x));
            chk("cyc_y", 32'(bus.y), 32'(m_y));
            chk("cyc_colour", 32'(bus.colour), 32'(m_c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.req       = '0;
        bus.valid     = '0;
        bus.last      = '0;
        bus.px_x      = '0;
        bus.px_y      = '0;
        bus.px_colour = '0;
        bus.freeze    = 1'b0;
    endtask

    task automatic set_px(input int r, input int xx, input int yy, input int cc, input bit v, input bit l);
        bus.valid[r]               = v;
        bus.last[r]                = l;
        bus.px_x[r*8 +: 8]         = 8'(xx);
        bus.px_y[r*7 +: 7]         = 7'(yy);
        bus.px_colour[r*24 +: 24]  = 24'(cc);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_in();
        step();
        step();
    endtask

    int          order [4];
    int          w;
    int          to_pulses;
    logic [3:0]  pat;

    initial begin
        resetn = 1'b0;
        clear_in();
        cmp_en = 1'b1;

        // Reset state and a single 4-pixel burst from requester 0.
        do_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_colour", 32'(bus.colour), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        resetn = 1'b1;
        bus.req = 3'b001;
        step();
        chk("t1_gnt", 32'(bus.gnt), 32'b001);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_plot_pre", 32'(bus.plot), 32'd0);
        for (int p = 0; p < 4; p++) begin
            set_px(0, 10 + p, 20, 24'hFF0000, 1'b1, p == 3);
            if (p == 3) bus.req = 3'b000;
            step();
            chk("t1_plot", 32'(bus.plot), 32'd1);
            chk("t1_x", 32'(bus.x), 32'(10 + p));
            chk("t1_y", 32'(bus.y), 32'd20);
            chk("t1_colour", 32'(bus.colour), 32'hFF0000);
            chk("t1_gnt_burst", 32'(bus.gnt), (p == 3) ? 32'd0 : 32'b001);
        end
        set_px(0, 0, 0, 0, 1'b0, 1'b0);
        step();
        chk("t1_plot_end", 32'(bus.plot), 32'd0);
        chk("t1_gnt_end", 32'(bus.gnt), 32'd0);

        // All three requesting: order 0,1,2,0 with exactly one dead cycle between bursts.
        do_reset();
        resetn = 1'b1;
        bus.req = 3'b111;
        order = '{0, 1, 2, 0};
        for (int b = 0; b < 4; b++) begin
            w = order[b];
            step();
            chk("t2_gnt_order", 32'(bus.gnt), 32'd1 << w);
            for (int p = 0; p < 2; p++) begin
                set_px(w, 40 + b * 2 + p, 50 + w, 24'h000100 * b + p, 1'b1, p == 1);
                step();
                chk("t2_plot", 32'(bus.plot), 32'd1);
                chk("t2_x", 32'(bus.x), 32'(40 + b * 2 + p));
                if (p == 1) chk("t2_gap", 32'(bus.gnt), 32'd0);
            end
            set_px(w, 0, 0, 0, 1'b0, 1'b0);
        end
        bus.req = 3'b000;
        step();
        chk("t2_gnt_end", 32'(bus.gnt), 32'd0);

        // Non-owner valid with x=99 must never leak onto the adapter port.
        pat = 4'b1101;
        set_px(1, 99, 99, 24'hABCDEF, 1'b1, 1'b0);
        bus.req = 3'b001;
        step();
        chk("t3_gnt", 32'(bus.gnt), 32'b001);
        chk("t3_plot_idle", 32'(bus.plot), 32'd0);
        for (int p = 0; p < 4; p++) begin
            set_px(0, 60 + p, 70, 24'h0000FF, pat[p], p == 3);
            if (p == 3) bus.req = 3'b000;
            step();
            chk("t3_plot", 32'(bus.plot), 32'(pat[p]));
            chk("t3_no_leak", 32'(bus.x == 8'd99), 32'd0);
        end
        chk("t3_x_last", 32'(bus.x), 32'd63);
        clear_in();
        step();
        chk("t3_gnt_end", 32'(bus.gnt), 32'd0);

        // Stalled owner: revoked after IDLE_LIMIT idle cycles, next requester follows.
        do_reset();
        resetn = 1'b1;
        bus.req = 3'b011;
        to_pulses = 0;
        step();
        chk("t4_gnt", 32'(bus.gnt), 32'b001);
        for (int i = 1; i < IDLE_LIMIT; i++) begin
            step();
            chk("t4_gnt_hold", 32'(bus.gnt), 32'b001);
            if (bus.timeout) to_pulses++;
        end
        step();
        chk("t4_gnt_revoked", 32'(bus.gnt), 32'd0);
        chk("t4_timeout", 32'(bus.timeout), 32'd1);
        chk("t4_plot", 32'(bus.plot), 32'd0);
        if (bus.timeout) to_pulses++;
        step();
        chk("t4_next_gnt", 32'(bus.gnt), 32'b010);
        if (bus.timeout) to_pulses++;
        chk("t4_pulse_count", 32'(to_pulses), 32'd1);
        set_px(1, 5, 5, 1, 1'b1, 1'b1);
        bus.req = 3'b000;
        step();
        chk("t4_plot_r1", 32'(bus.plot), 32'd1);
        clear_in();
        step();

        // freeze during requester 2's burst: burst finishes, no new grant until freeze drops.
        do_reset();
        resetn = 1'b1;
        bus.req = 3'b100;
        step();
        chk("t5_gnt", 32'(bus.gnt), 32'b100);
        bus.req = 3'b101;
        bus.freeze = 1'b1;
        for (int p = 0; p < 3; p++) begin
            set_px(2, 80 + p, 90, 24'h00FF00, 1'b1, p == 2);
            step();
            chk("t5_plot", 32'(bus.plot), 32'd1);
            chk("t5_gnt_burst", 32'(bus.gnt), (p == 2) ? 32'd0 : 32'b100);
        end
        set_px(2, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_frozen_gnt", 32'(bus.gnt), 32'd0);
        end
        bus.freeze = 1'b0;
        step();
        chk("t5_thaw_gnt", 32'(bus.gnt), 32'b001);
        set_px(0, 1, 1, 1, 1'b1, 1'b1);
        bus.req = 3'b000;
        step();
        clear_in();
        step();

        // Reset asserted on the 3rd pixel clears outputs at once; requester 0 wins afterwards.
        do_reset();
        resetn = 1'b1;
        bus.req = 3'b001;
        step();
        chk("t6_gnt", 32'(bus.gnt), 32'b001);
        for (int p = 0; p < 2; p++) begin
            set_px(0, 100 + p, 10, 24'h123456, 1'b1, 1'b0);
            step();
        end
        chk("t6_x_pre", 32'(bus.x), 32'd101);
        set_px(0, 102, 10, 24'h123456, 1'b1, 1'b0);
        #3;
        resetn = 1'b0;
        #1;
        chk("t6_plot_async", 32'(bus.plot), 32'd0);
        chk("t6_gnt_async", 32'(bus.gnt), 32'd0);
        chk("t6_x_async", 32'(bus.x), 32'd0);
        chk("t6_y_async", 32'(bus.y), 32'd0);
        chk("t6_colour_async", 32'(bus.colour), 32'd0);
        chk("t6_busy_async", 32'(bus.busy), 32'd0);
        clear_in();
        bus.req = 3'b011;
        resetn = 1'b1;
        step();
        chk("t6_gnt_after", 32'(bus.gnt), 32'b001);
        chk("t6_plot_after", 32'(bus.plot), 32'd0);
        set_px(0, 1, 1, 1, 1'b1, 1'b1);
        bus.req = 3'b000;
        step();
        clear_in();
        step();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
